// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the RV32 pipeline datapath and the hazard/stall sequencer.
// The datapath side (master) supplies the hazard sources; the sequencer (slave) returns enables.
interface hazard_stall_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           ID_RS1;
  logic [4:0]           ID_RS2;
  logic                 ID_USES_RS1;
  logic                 ID_USES_RS2;
  logic [4:0]           EX_RD;
  logic                 EX_MEM_READ;
  logic                 PC_SEL;
  logic                 DMEM_BUSY;
  logic                 PC_WRITE_EN;
  logic                 IF_ID_WRITE_EN;
  logic                 ID_EX_WRITE_EN;
  logic                 EX_MEM_WRITE_EN;
  logic                 IF_ID_FLUSH;
  logic                 ID_EX_BUBBLE;
  logic                 MEM_WB_BUBBLE;
  logic [1:0]           STATE;
  logic                 HALTED;
  logic [CNT_WIDTH-1:0] STALL_CNT;
  logic [CNT_WIDTH-1:0] FLUSH_CNT;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ, PC_SEL, DMEM_BUSY,
    input  PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_WRITE_EN, EX_MEM_WRITE_EN,
    input  IF_ID_FLUSH, ID_EX_BUBBLE, MEM_WB_BUBBLE, STATE, HALTED, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ, PC_SEL, DMEM_BUSY,
    output PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_WRITE_EN, EX_MEM_WRITE_EN,
    output IF_ID_FLUSH, ID_EX_BUBBLE, MEM_WB_BUBBLE, STATE, HALTED, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32 core: load-use stalls, EX-resolved flushes,
// data-memory freeze with timeout halt, and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  hazard_stall_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [7:0]           wait_cnt, wait_nxt;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
  logic                 lu;
  logic                 pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic                 if_id_flush, id_ex_bubble, mem_wb_bubble;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign lu = bus.EX_MEM_READ && (bus.EX_RD != 5'd0) &&
              ((bus.ID_USES_RS1 && (bus.ID_RS1 == bus.EX_RD)) ||
               (bus.ID_USES_RS2 && (bus.ID_RS2 == bus.EX_RD)));

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    state_nxt     = state;
    wait_nxt      = wait_cnt;

    if (RESET) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      state_nxt     = RUN;
      wait_nxt      = 8'd0;
    end else if (state == HALT) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.DMEM_BUSY) begin
      // Freeze everything up to EX/MEM; MEM/WB drains a NOP while memory is busy.
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
      if (state != MEM_WAIT) begin
        state_nxt = MEM_WAIT;
        wait_nxt  = 8'd1;
      end else if (wait_cnt == WAIT_LAST) begin
        state_nxt = HALT;
      end else begin
        wait_nxt = wait_cnt + 8'd1;
      end
    end else begin
      wait_nxt = 8'd0;
      if (bus.PC_SEL) begin
        // Squashing the ID instruction makes any concurrent load-use hazard moot.
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_nxt    = RUN;
      end else if (lu) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
        state_nxt    = LU_STALL;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_we && (state != HALT))
        stall_cnt <= sat_inc(stall_cnt);
      if (if_id_flush)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.PC_WRITE_EN     = pc_we;
  assign bus.IF_ID_WRITE_EN  = if_id_we;
  assign bus.ID_EX_WRITE_EN  = id_ex_we;
  assign bus.EX_MEM_WRITE_EN = ex_mem_we;
  assign bus.IF_ID_FLUSH     = if_id_flush;
  assign bus.ID_EX_BUBBLE    = id_ex_bubble;
  assign bus.MEM_WB_BUBBLE   = mem_wb_bubble;
  assign bus.STATE           = state;
  assign bus.HALTED          = (state == HALT);
  assign bus.STALL_CNT       = stall_cnt;
  assign bus.FLUSH_CNT       = flush_cnt;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall sequencer for the 5-stage RV32 core. Each cycle it decides write-enable, flush and bubble for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sources are load-use hazards detected across ID/EX, taken branches/jumps resolved in EX (PC_SEL), and data-memory wait states. It also tracks a data-memory timeout that halts the core, and keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive DMEM_BUSY cycles that force HALT (legal 2..255)
- CNT_WIDTH, 16: width of the performance counters
- CLK in 1: single clock, all state updates on posedge
- RESET in 1: synchronous, active-high
- ID_RS1, ID_RS2 in 5: source register fields of the instruction in ID
- ID_USES_RS1, ID_USES_RS2 in 1: ID instruction actually reads rs1 / rs2
- EX_RD in 5: destination field (INSTRUCTION[11:7]) held in ID/EX
- EX_MEM_READ in 1: instruction in EX is a load
- PC_SEL in 1: taken branch/jump resolved in EX this cycle
- DMEM_BUSY in 1: data memory not ready for the MEM-stage access
- PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_WRITE_EN, EX_MEM_WRITE_EN out 1: register load enables
- IF_ID_FLUSH out 1: IF/ID loads a NOP
- ID_EX_BUBBLE out 1: ID/EX loads a NOP (REG_WRITE_EN=0, no memory access)
- MEM_WB_BUBBLE out 1: MEM/WB loads a NOP
- STATE out 2: 0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 HALT
- HALTED out 1: STATE==HALT
- STALL_CNT, FLUSH_CNT out CNT_WIDTH: saturating performance counters

## Operation
- Outputs are combinational from the registered state and the current inputs (Mealy). State, wait counter and performance counters are registered.
- Hazard term: lu = EX_MEM_READ && EX_RD!=0 && ((ID_USES_RS1 && ID_RS1==EX_RD) || (ID_USES_RS2 && ID_RS2==EX_RD)).
- Default outputs: all WRITE_EN=1, IF_ID_FLUSH=0, ID_EX_BUBBLE=0, MEM_WB_BUBBLE=0.
- In RUN and LU_STALL, first matching rule wins:
  - DMEM_BUSY: freeze. PC, IF/ID, ID/EX and EX/MEM WRITE_EN=0; MEM_WB_BUBBLE=1. Next state MEM_WAIT; wait_cnt←1.
  - PC_SEL: flush. IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE_EN=1. Next state RUN. Any simultaneous lu is ignored because the ID instruction is squashed.
  - lu: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1. Next state LU_STALL.
  - otherwise: defaults; next state RUN.
- MEM_WAIT:
  - DMEM_BUSY=1: freeze outputs as above. If wait_cnt==MEM_TIMEOUT-1, next state is HALT; otherwise wait_cnt increments.
  - DMEM_BUSY=0: evaluate the PC_SEL and lu rules as in RUN, then go to RUN or LU_STALL accordingly. wait_cnt←0.
  - A PC_SEL held during the freeze is acted on in the first non-busy cycle.
- HALT: all WRITE_EN=0, MEM_WB_BUBBLE=1, HALTED=1. Only RESET leaves this state.
- STALL_CNT increments in any cycle with PC_WRITE_EN=0, excluding HALT and RESET cycles.
- FLUSH_CNT increments in any cycle with IF_ID_FLUSH=1.
- Both counters saturate at all-ones and never wrap.

## Timing
- RESET sampled high at a posedge gives: STATE=RUN, wait_cnt=0, STALL_CNT=0, FLUSH_CNT=0, HALTED=0.
- While RESET is high, outputs are forced to: all WRITE_EN=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, MEM_WB_BUBBLE=1. Counters do not increment.
- Reset mid-MEM_WAIT or in HALT returns the block to RUN on the next edge; nothing pending survives.
- Flush and bubble take effect at the same edge their input is seen: zero-cycle decision latency.
- A load-use hazard inserts exactly one bubble. After the stall the load is in MEM, so lu is 0 in LU_STALL unless a new load has entered EX.
- HALT is entered at the edge that ends the MEM_TIMEOUT-th consecutive busy cycle; HALTED is visible on the following cycle.

## Test plan
- Load x5 in EX, ID uses rs2=x5 → one cycle with PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1; STATE=1 next cycle, then RUN; STALL_CNT=1.
- Load with EX_RD=0 and ID_RS1=0, ID_USES_RS1=1 → no stall, all defaults.
- PC_SEL=1 with lu=1 in the same cycle → IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE_EN=1; FLUSH_CNT=1, STALL_CNT=0.
- DMEM_BUSY high for 3 cycles with PC_SEL=1 throughout → 3 freeze cycles with MEM_WB_BUBBLE=1, then a flush cycle; STALL_CNT=3, FLUSH_CNT=1, STATE RUN.
- MEM_TIMEOUT=4, DMEM_BUSY held high → after 4 busy cycles HALTED=1, STATE=3. Enables stay 0 after DMEM_BUSY drops; RESET restores RUN with counters 0.
- CNT_WIDTH=4 with 20 consecutive load-use stalls → STALL_CNT saturates at 15.
